frame_step_gen: RTL

FRAME_STEP_GEN -- requirements
Module: frame_step_gen

---
 rtl/frame_step_pkg.sv | 26 ++
 rtl/btn_debouncer.sv | 103 ++++++++++
 rtl/frame_step_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/frame_step_pkg.sv
// ---------------------------------------------------------------------------
// frame_step_pkg
// Shared definitions for the frame step generator and its button debouncer:
// default frame/step ratio, default debounce interval, the frameCount width,
// the debouncer state encoding and a small counter-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package frame_step_pkg;

    localparam int FRAMES_PER_STEP_DEF = 30;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int FRAME_CNT_W         = 6;

    typedef enum logic [1:0] {
        DB_RELEASED  = 2'd0,
        DB_CHK_PRESS = 2'd1,
        DB_PRESSED   = 2'd2,
        DB_CHK_REL   = 2'd3
    } db_state_t;

    // Bits needed to hold a count of 0 .. maxVal-1, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal);
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
// Synchronises a raw push button and filters contact bounce. A press is
// accepted once the synchronised level has stayed high for DEBOUNCE_CYCLES
// cycles after leaving RELEASED; a release needs the same stable-low run.
// Ports:
//   clock    - rising-edge clock
//   resetN   - asynchronous active-low reset
//   i_raw    - raw button level, asynchronous to clock
//   o_press  - registered one-cycle strobe per accepted press
// ---------------------------------------------------------------------------
module btn_debouncer
    import frame_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)(
    input  logic clock,
    input  logic resetN,
    input  logic i_raw,
    output logic o_press
);

    localparam int            CW   = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    db_state_t     r_state;
    db_state_t     w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          r_press;
    logic          w_pressNext;

    // Two-flop synchronizer for the raw button; reset to released.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, stability counter and press strobe registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= DB_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_press <= w_pressNext;
        end
    end

    // Next-state logic. The counter only runs in the two checking states and
    // restarts from zero whenever the level disagrees with the candidate.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = '0;
        w_pressNext = 1'b0;
        case (r_state)
            DB_RELEASED: begin
                if (r_sync2) begin
                    w_stateNext = DB_CHK_PRESS;
                end
            end
            DB_CHK_PRESS: begin
                if (!r_sync2) begin
                    w_stateNext = DB_RELEASED;
                end else if (r_cnt == LAST) begin
                    w_stateNext = DB_PRESSED;
                    w_pressNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            DB_PRESSED: begin
                if (!r_sync2) begin
                    w_stateNext = DB_CHK_REL;
                end
            end
            DB_CHK_REL: begin
                if (r_sync2) begin
                    w_stateNext = DB_PRESSED;
                end else if (r_cnt == LAST) begin
                    w_stateNext = DB_RELEASED;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            default: begin
                w_stateNext = DB_RELEASED;
            end
        endcase
    end

    assign o_press = r_press;

endmodule

// File: rtl/frame_step_gen.sv
// ---------------------------------------------------------------------------
// frame_step_gen
// Counts vsync frames and emits a one-cycle step strobe every FRAMES_PER_STEP
// frames while run is high. The strobe always has a low cycle between pulses;
// a request arriving while the strobe is high is held (at most one) and issued
// on the next legal cycle.
// Optional feature: define FRAME_STEP_MANUAL_EN to add the manualBtn port and
// a debounced manual step that works regardless of run.
// Ports:
//   clock      - sole clock, rising edge
//   resetN     - asynchronous active-low reset
//   vsyncIn    - raw vsync, asynchronous to clock
//   run        - high enables automatic stepping
//   manualBtn  - raw push button (FRAME_STEP_MANUAL_EN only)
//   stepPulse  - registered one-cycle step strobe
//   frameCount - frames counted toward the next step
// ---------------------------------------------------------------------------
module frame_step_gen
    import frame_step_pkg::*;
#(
    parameter int FRAMES_PER_STEP  = FRAMES_PER_STEP_DEF,
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF
)(
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   vsyncIn,
    input  logic                   run,
`ifdef FRAME_STEP_MANUAL_EN
    input  logic                   manualBtn,
`endif
    output logic                   stepPulse,
    output logic [FRAME_CNT_W-1:0] frameCount
);

    localparam logic                   VSYNC_IDLE = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [FRAME_CNT_W-1:0] LAST_CNT   = FRAME_CNT_W'(FRAMES_PER_STEP - 1);

    // Elaboration-time parameter legality checks.
    if (FRAMES_PER_STEP < 1 || FRAMES_PER_STEP > 63) begin : g_badFrames
        $error("frame_step_gen: FRAMES_PER_STEP must be 1..63");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
        $error("frame_step_gen: DEBOUNCE_CYCLES must be at least 1");
    end

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_syncPrev;
    logic                   r_frameTick;
    logic [FRAME_CNT_W-1:0] r_frameCount;
    logic                   r_stepPulse;
    logic                   r_pending;
    logic                   w_autoReq;
    logic                   w_manualReq;
    logic                   w_stepReq;

    // Synchronizer plus one history flop; all reset to the inactive level so
    // reset release cannot look like a vsync edge. frameTick is registered,
    // landing three clocks after the raw edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_sync1     <= VSYNC_IDLE;
            r_sync2     <= VSYNC_IDLE;
            r_syncPrev  <= VSYNC_IDLE;
            r_frameTick <= 1'b0;
        end else begin
            r_sync1     <= vsyncIn;
            r_sync2     <= r_sync1;
            r_syncPrev  <= r_sync2;
            r_frameTick <= (r_sync2 != VSYNC_IDLE) && (r_syncPrev == VSYNC_IDLE);
        end
    end

    assign w_autoReq = r_frameTick && run && (r_frameCount == LAST_CNT);

`ifdef FRAME_STEP_MANUAL_EN
    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock  (clock),
        .resetN (resetN),
        .i_raw  (manualBtn),
        .o_press(w_manualReq)
    );
`else
    assign w_manualReq = 1'b0;
`endif

    assign w_stepReq = w_autoReq || w_manualReq;

    // Frame counter: advances only on a tick with run high, wraps at the
    // last frame of the step (so it stays at 0 when FRAMES_PER_STEP is 1).
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_frameCount <= '0;
        end else if (r_frameTick && run) begin
            if (r_frameCount == LAST_CNT) begin
                r_frameCount <= '0;
            end else begin
                r_frameCount <= r_frameCount + 1'b1;
            end
        end
    end

    // Step strobe with a one-deep pending slot. A request during a high
    // strobe cycle is parked and fires after the mandatory low cycle;
    // simultaneous manual and automatic requests collapse into one pulse.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_stepPulse <= 1'b0;
            r_pending   <= 1'b0;
        end else if (r_stepPulse) begin
            r_stepPulse <= 1'b0;
            if (w_stepReq) begin
                r_pending <= 1'b1;
            end
        end else begin
            r_stepPulse <= w_stepReq || r_pending;
            r_pending   <= 1'b0;
        end
    end

    assign stepPulse  = r_stepPulse;
    assign frameCount = r_frameCount;

endmodule
